// File: rtl/commit_trace_streamer_pkg.sv
// Shared record layout, serializer state encoding and word-select helpers for commit_trace_streamer.
// Build option COMMIT_TRACE_TIMESTAMP_EN appends a 32-bit cycle stamp as a fifth record word.
package commit_trace_streamer_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned WADDR_W     = 5;
    localparam int unsigned W2_WEN_BIT  = 31;
    localparam int unsigned W2_DROP_BIT = 30;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    localparam int unsigned WORDS_PER_REC = 5;
`else
    localparam int unsigned WORDS_PER_REC = 4;
`endif
    localparam int unsigned LAST_IDX = WORDS_PER_REC - 1;

    // Word n of a record lives at bits [32n +: 32], so pc is the least significant field.
    typedef struct packed {
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        logic [WORD_W-1:0] ts;
`endif
        logic [WORD_W-1:0] w3;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

    // Wn is encoded as n+1 so the state value doubles as the index of the following word.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_W1   = 3'd2,
        ST_W2   = 3'd3,
        ST_W3   = 3'd4,
        ST_W4   = 3'd5
    } ser_state_e;

    function automatic logic [WORD_W-1:0] rec_word(input trace_rec_t rec, input logic [2:0] idx);
        logic [REC_W-1:0] flat;
        flat = rec;
        return flat[int'(idx)*WORD_W +: WORD_W];
    endfunction

    function automatic logic [WORD_W-1:0] make_w2(input logic wen, input logic drop,
                                                  input logic [WADDR_W-1:0] waddr);
        logic [WORD_W-1:0] w;
        w                = '0;
        w[W2_WEN_BIT]    = wen;
        w[W2_DROP_BIT]   = drop;
        w[WADDR_W-1:0]   = waddr;
        return w;
    endfunction

endpackage

// File: rtl/commit_trace_streamer_record_fifo.sv
// Synchronous record FIFO; a push while full is accepted when a pop happens in the same cycle.
// Record width follows COMMIT_TRACE_TIMESTAMP_EN through the WIDTH parameter set by the top.
module trace_record_fifo
    import commit_trace_streamer_pkg::*;
#(
    parameter int unsigned WIDTH = REC_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_c,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = (r_level == LW'(DEPTH));
    assign o_empty_c = (r_level == '0);
    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    assign w_pop  = i_pop && !o_empty_c;
    assign w_push = i_push && (!o_full_c || w_pop);

    // Storage is not reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_streamer.sv
// Captures retired-instruction records at MEM/WB and streams them as 32-bit words over valid/ready.
// Define COMMIT_TRACE_TIMESTAMP_EN to append a free-running cycle stamp as a fifth word.
module commit_trace_streamer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    input  logic [31:0]              commit_instr,
    input  logic                     commit_gpr_wen,
    input  logic [4:0]               commit_gpr_waddr,
    input  logic [31:0]              commit_gpr_wdata,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_data,
    output logic                     trace_last,
    output logic [DROP_W-1:0]        drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    import commit_trace_streamer_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    trace_rec_t         w_push_rec;
    trace_rec_t         w_head;
    logic [REC_W-1:0]   w_head_bits;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [LVL_W-1:0]   w_level;
    logic [2:0]         w_next_idx;

    logic               r_drop_pending;
    logic [DROP_W-1:0]  r_drop_count;
    ser_state_e         r_state;
    trace_rec_t         r_rec;
    logic               r_trace_valid;
    logic               r_trace_last;
    logic [WORD_W-1:0]  r_trace_data;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0]        r_cycle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    // Record assembly from the MEM/WB commit bus.
    always_comb begin
        w_push_rec       = '0;
        w_push_rec.pc    = commit_pc;
        w_push_rec.instr = commit_instr;
        w_push_rec.w2    = make_w2(commit_gpr_wen, r_drop_pending, commit_gpr_waddr);
        w_push_rec.w3    = commit_gpr_wen ? commit_gpr_wdata : '0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        w_push_rec.ts    = r_cycle;
`endif
    end

    // The serializer pops when idle or when the last word of the current record handshakes.
    assign w_pop      = !w_fifo_empty &&
                        ((r_state == ST_IDLE) || (r_trace_valid && trace_ready && r_trace_last));
    assign w_push_req = commit_valid && trace_en;
    assign w_push     = w_push_req && (!w_fifo_full || w_pop);
    assign w_drop     = w_push_req && !w_push;
    assign w_head     = trace_rec_t'(w_head_bits);
    assign w_next_idx = 3'(r_state);

    trace_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_data    (w_push_rec),
        .i_pop     (w_pop),
        .o_head_c  (w_head_bits),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty),
        .o_level   (w_level)
    );

    // Overflow bookkeeping: saturating drop counter and a flag for the next accepted record.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count   <= '0;
            r_drop_pending <= 1'b0;
        end else begin
            if (w_drop) begin
                r_drop_pending <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + DROP_W'(1);
                end
            end else if (w_push) begin
                r_drop_pending <= 1'b0;
            end
        end
    end

    // Word serializer; a pop on the last-word handshake starts the next record with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rec         <= '0;
            r_trace_valid <= 1'b0;
            r_trace_last  <= 1'b0;
            r_trace_data  <= '0;
        end else if (w_pop) begin
            r_rec         <= w_head;
            r_trace_data  <= w_head.pc;
            r_trace_valid <= 1'b1;
            r_trace_last  <= 1'b0;
            r_state       <= ST_W0;
        end else if (r_trace_valid && trace_ready) begin
            if (r_trace_last) begin
                r_trace_valid <= 1'b0;
                r_trace_last  <= 1'b0;
                r_state       <= ST_IDLE;
            end else begin
                r_trace_data  <= rec_word(r_rec, w_next_idx);
                r_trace_last  <= (w_next_idx == 3'(LAST_IDX));
                r_state       <= ser_state_e'(r_state + 3'd1);
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_data  = r_trace_data;
    assign trace_last  = r_trace_last;
    assign drop_count  = r_drop_count;
    assign fifo_level  = w_level;

endmodule

// File: tb/tb_commit_trace_streamer.sv
// Scoreboard bench for commit_trace_streamer; expected words are queued at commit time.
// Also covers the COMMIT_TRACE_TIMESTAMP_EN build via a bench-side cycle model.
module tb_commit_trace_streamer;
    import commit_trace_streamer_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              trace_en;
    logic              commit_valid;
    logic [31:0]       commit_pc;
    logic [31:0]       commit_instr;
    logic              commit_gpr_wen;
    logic [4:0]        commit_gpr_waddr;
    logic [31:0]       commit_gpr_wdata;
    logic              trace_valid;
    logic              trace_ready;
    logic [31:0]       trace_data;
    logic              trace_last;
    logic [DROP_W-1:0] drop_count;
    logic [LVL_W-1:0]  fifo_level;

    logic [32:0] sb[$];
    int n_cmp = 0;
    int n_mis = 0;

    commit_trace_streamer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .trace_en         (trace_en),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_instr     (commit_instr),
        .commit_gpr_wen   (commit_gpr_wen),
        .commit_gpr_waddr (commit_gpr_waddr),
        .commit_gpr_wdata (commit_gpr_wdata),
        .trace_valid      (trace_valid),
        .trace_ready      (trace_ready),
        .trace_data       (trace_data),
        .trace_last       (trace_last),
        .drop_count       (drop_count),
        .fifo_level       (fifo_level)
    );

    always #5 clk = ~clk;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0] tb_cyc = 32'd0;
    always @(posedge clk) begin
        if (reset) tb_cyc <= 32'd0;
        else       tb_cyc <= tb_cyc + 32'd1;
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected word.
    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (!reset && trace_valid && trace_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_word: got 0x%08h expected none", trace_data);
            end else begin
                e = sb.pop_front();
                check("word_data", trace_data, e[31:0]);
                check("word_last", 32'(trace_last), 32'(e[32]));
            end
        end
    end

    task automatic commit(input logic [31:0] pc, input logic [31:0] instr, input logic wen,
                          input logic [4:0] waddr, input logic [31:0] wdata,
                          input bit accept, input bit df);
        commit_valid     = 1'b1;
        commit_pc        = pc;
        commit_instr     = instr;
        commit_gpr_wen   = wen;
        commit_gpr_waddr = waddr;
        commit_gpr_wdata = wdata;
        if (accept) begin
            sb.push_back({1'b0, pc});
            sb.push_back({1'b0, instr});
            sb.push_back({1'b0, wen, df, 25'b0, waddr});
`ifdef COMMIT_TRACE_TIMESTAMP_EN
            sb.push_back({1'b0, (wen ? wdata : 32'h0)});
            sb.push_back({1'b1, tb_cyc});
`else
            sb.push_back({1'b1, (wen ? wdata : 32'h0)});
`endif
        end
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((sb.size() != 0 || trace_valid) && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k >= budget) begin
            n_mis++;
            $display("FAIL %s_drain: got %0d words pending expected 0", name, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; trace_en = 1'b1; trace_ready = 1'b1; commit_valid = 1'b0;
        commit_pc = '0; commit_instr = '0; commit_gpr_wen = 1'b0;
        commit_gpr_waddr = '0; commit_gpr_wdata = '0;
        repeat (3) tick();
        check("rst_valid", 32'(trace_valid), 32'd0);
        check("rst_data",  trace_data,        32'd0);
        check("rst_last",  32'(trace_last),  32'd0);
        check("rst_drop",  32'(drop_count),  32'd0);
        check("rst_level", 32'(fifo_level),  32'd0);
        reset = 1'b0;
        tick();

        // Single commit and two-cycle latency
        commit(32'h0040_0000, 32'h2408_0005, 1'b1, 5'd8, 32'h5, 1'b1, 1'b0);
        check("t1_valid_n1", 32'(trace_valid), 32'd0);
        check("t1_level_n1", 32'(fifo_level),  32'd1);
        tick();
        check("t1_valid_n2", 32'(trace_valid), 32'd1);
        check("t1_w0_n2",    trace_data,        32'h0040_0000);
        wait_drain("t1", 40);

        // Backpressure during W1
        commit(32'h0040_0000, 32'h2408_0005, 1'b1, 5'd8, 32'h5, 1'b1, 1'b0);
        tick();
        tick();
        trace_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("t2_hold_valid", 32'(trace_valid), 32'd1);
            check("t2_hold_data",  trace_data,        32'h2408_0005);
            tick();
        end
        trace_ready = 1'b1;
        tick();
        check("t2_w2_after", trace_data, 32'h8000_0008);
        wait_drain("t2", 40);

        // Overflow: a held blocker record keeps the serializer busy
        trace_ready = 1'b0;
        commit(32'h0000_1000, 32'h0000_0013, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            commit(32'h2000 + 32'(i * 4), 32'h100 + 32'(i), (i % 2 == 0), 5'(i),
                   32'hA000 + 32'(i), (i < 16), 1'b0);
        end
        check("t3_level_full", 32'(fifo_level), 32'd16);
        check("t3_drop4",      32'(drop_count), 32'd4);
        check("t3_blk_w0",     trace_data,       32'h0000_1000);
        trace_ready = 1'b1;
        tick();
        tick();
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        tick();
`endif
        tick();
        // Full FIFO with the last-word pop in the same cycle
        check("t4_last",  32'(trace_last), 32'd1);
        commit(32'h0000_3000, 32'h0000_0003, 1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check("t4_level", 32'(fifo_level), 32'd16);
        check("t4_drop",  32'(drop_count), 32'd4);
        wait_drain("t3", 400);
        commit(32'h0000_4000, 32'h0000_0004, 1'b1, 5'd1, 32'h1, 1'b1, 1'b0);
        wait_drain("t3b", 40);
        check("t3_drop_kept", 32'(drop_count), 32'd4);

        // Back-to-back drain of three records
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            commit(32'h5000 + 32'(i * 4), 32'h500 + 32'(i), 1'b1, 5'(i + 1),
                   32'h50 + 32'(i), 1'b1, 1'b0);
        end
        trace_ready = 1'b1;
        for (int i = 0; i < 3 * int'(WORDS_PER_REC); i++) begin
            check("t5_no_bubble", 32'(trace_valid), 32'd1);
            tick();
        end
        check("t5_valid_fall", 32'(trace_valid), 32'd0);
        check("t5_sb_empty",   32'(sb.size()),   32'd0);

        // Reset in the middle of a record
        commit(32'h0000_6000, 32'h0000_0006, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        check("t6_w2_before", trace_data, 32'h8000_0006);
        reset = 1'b1;
        sb.delete();
        tick();
        check("t6_valid", 32'(trace_valid), 32'd0);
        check("t6_level", 32'(fifo_level),  32'd0);
        check("t6_drop",  32'(drop_count),  32'd0);
        check("t6_last",  32'(trace_last),  32'd0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        commit(32'h0000_7000, 32'h0000_0007, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        wait_drain("t6", 40);

        check("end_sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/commit_trace_streamer.md
Name: commit_trace_streamer

Overview:
- On-chip counterpart of the bench-side commit dump: captures each retired instruction's pc, instr and GPR write-back at the MEM/WB boundary of core0.
- Buffers retired records in a record FIFO and streams them out as 32-bit words over a valid/ready port toward a host-side reader (debug UART bridge or bench monitor).
- Makes pc/instr/regfile trace observable without hierarchical peeking.

Parameters:
- DEPTH, 16, record FIFO entries; power of two, ≥2
- DROP_W, 16, width of saturating dropped-record counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trace_en  in  1  capture enable; sampled each cycle
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  32  pc of retiring instruction
- commit_instr  in  32  retiring instruction word
- commit_gpr_wen  in  1  retiring instruction writes a GPR
- commit_gpr_waddr  in  5  destination GPR index
- commit_gpr_wdata  in  32  value written
- trace_valid  out  1  trace_data holds a valid word
- trace_ready  in  1  downstream accepts word
- trace_data  out  32  trace word
- trace_last  out  1  final word of current record
- drop_count  out  DROP_W  saturating count of records lost to overflow
- fifo_level  out  $clog2(DEPTH)+1  occupied record entries

Behaviour:
- Reset values: trace_valid=0, trace_data=0, trace_last=0, drop_count=0, fifo_level=0; FIFO pointers 0; serializer IDLE; pending-drop flag 0.
- Reset mid-stream discards the partial record and all buffered records; no resumption.
- Capture: push when commit_valid && trace_en. Record =
  - W0 = pc
  - W1 = instr
  - W2 = {wen, drop_flag, 25'b0, waddr}
  - W3 = wdata, or 0 when wen=0
- Push condition: fifo_level < DEPTH, or a pop occurs the same cycle.
- Overflow: if neither holds, the record is dropped, drop_count increments (saturates at all-ones), and the pending-drop flag is set.
  - The next accepted record carries drop_flag=1 in W2[30]; the flag clears on that push.
- fifo_level updates at the clock edge: +1 on push only, −1 on pop only, unchanged on both.
- Serializer FSM, states IDLE, W0, W1, W2, W3 (W4 when timestamp enabled):
  - IDLE: if FIFO non-empty, pop the head, load the word register with W0, set trace_valid=1, go to W0.
  - Wn: hold trace_data stable while trace_valid && !trace_ready.
  - On a handshake (valid && ready) advance to the next word.
  - Handshake on the last word: trace_last was 1 during that word. If FIFO non-empty, pop and present the next record's W0 in the very next cycle (no bubble). Otherwise deassert trace_valid and go to IDLE.
- Latency: commit in cycle N with FIFO empty and serializer IDLE → W0 on trace_data in cycle N+2 (push at edge N, pop at edge N+1). Sustained throughput is one word per cycle when ready=1.
- trace_en deassert: stops new pushes only; buffered records drain normally.
- trace_valid never drops without a handshake except on reset.

Optional Feature:
- Macro COMMIT_TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter, reset to 0 and wrapping at 2^32, is captured with each pushed record.
  - The counter value is appended as W4; trace_last moves to W4; records are 5 words.
  - FIFO width grows to 160 bits.
- Undefined: 4-word records, no counter logic.

Decomposition:
- Shared package: record field offsets (W2 wen bit 31, drop bit 30, waddr [4:0]), words-per-record constant (4 or 5 depending on macro), serializer state encoding.
- One natural sub-module: trace_record_fifo. Generic synchronous FIFO of width-parameterised records with push/pop/full/empty/level, and same-cycle push-when-full-with-pop allowed.
- The FSM and drop logic stay in the top module.

Test Plan:
- Single commit: pc=0x00400000, instr=0x24080005, wen=1, waddr=8, wdata=5, trace_ready=1.
  → W0 appears 2 cycles later.
  → Words 0x00400000, 0x24080005, 0x80000008, 0x00000005; trace_last=1 only on the 4th.
- Backpressure: trace_ready=0 for 7 cycles during W1.
  → trace_data stays 0x24080005 and trace_valid stays 1.
  → W2 follows the cycle after ready rises.
- Overflow with DEPTH=16 and trace_ready=0: 20 back-to-back commits.
  → fifo_level=16, drop_count=4.
  → Release ready: 16 records out. The next commit streams with W2[30]=1, and the one after with W2[30]=0.
- Full plus simultaneous pop: FIFO full, serializer finishing W3 with ready=1, commit_valid=1.
  → Record accepted, drop_count unchanged, fifo_level stays 16.
- Back-to-back drain: 3 records buffered, ready=1.
  → 12 consecutive valid words, no bubble; trace_valid falls after the 12th.
- Reset mid-record: assert reset during W2.
  → Next cycle: trace_valid=0, fifo_level=0, drop_count=0.
  → With COMMIT_TRACE_TIMESTAMP_EN, the first post-reset commit in cycle 3 after reset release carries W4=3.
